fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO, living entirely in the rd_clk domain.
//  Drains 8-bit entries with the FIFO's rd/valid/empty protocol.
//  Packs PACK_RATIO consecutive bytes into one wide word.
//  Presents each word on a valid/ready output handshake to the downstream datapath.
// PARAMETERS
//  DATA_WIDTH      8   width of one FIFO entry
//  PACK_RATIO      4   FIFO entries per output word (>=2)
//  TIMEOUT_CYCLES  16  idle cycles before a partial word is flushed (RD_PACK_TIMEOUT_EN only)
// PORTS
//  rd_clk          in   1                      single clock, same clock as the FIFO read side
//  rst             in   1                      synchronous, active-high reset
//  fifo_rd         out  1                      read strobe to FIFO
//  fifo_rdata      in   DATA_WIDTH             FIFO read data
//  fifo_valid      in   1                      fifo_rdata is valid this cycle
//  fifo_empty      in   1                      FIFO empty flag
//  fifo_underflow  in   1                      FIFO underflow flag
//  out_data        out  DATA_WIDTH*PACK_RATIO  packed word; byte 0 (first read) in [DATA_WIDTH-1:0]
//  out_keep        out  PACK_RATIO             per-byte valid mask
//  out_valid       out  1                      out_data/out_keep valid
//  out_ready       in   1                      downstream accepts when out_valid && out_ready
//  err_underflow   out  1                      sticky; set on any fifo_underflow, cleared only by rst
// BEHAVIOUR
//  Reset (sync, rst=1 at a rd_clk edge)
//   - fifo_rd=0, out_valid=0, out_data=0, out_keep=0, err_underflow=0.
//   - byte count=0, inflight=0, state=FILL; partial word discarded.
//  FIFO read protocol
//   - fifo_valid is asserted with data exactly 1 cycle after fifo_rd.
//   - At most one read in flight: fifo_rd=1 iff state==FILL && !fifo_empty && !inflight && !rst.
//   - Peak throughput is therefore 1 byte per 2 cycles; fifo_rd can never cause FIFO underflow.
//   - Any fifo_valid while inflight==0 (e.g. first cycle after reset) is dropped silently.
//  States
//   - FILL: each accepted byte goes to lane cnt, then cnt++.
//     When cnt reaches PACK_RATIO: load the output register, out_keep=all-ones, go to HOLD.
//   - HOLD: out_valid=1; out_data and out_keep stable; no FIFO reads.
//     On out_valid && out_ready: out_valid=0 next cycle, cnt=0, go to FILL.
//   - Minimum latency: last byte's fifo_valid -> out_valid is 1 cycle.
//     Worst-case full-rate word period is 2*PACK_RATIO+1 cycles.
//  Boundaries
//   - out_ready held high while in FILL: no effect.
//   - fifo_empty toggling mid-word: the partial word is held, unflushed unless the macro is set.
//   - fifo_underflow=1: err_underflow latches 1; data path unaffected.
//   - Reset while in HOLD: word dropped; out_valid=0 the following cycle.
// CONFIGURATION
//  RD_PACK_TIMEOUT_EN defined:
//   - In FILL with 0<cnt<PACK_RATIO and no read in flight, an idle counter increments each cycle.
//   - The counter clears on any accepted byte.
//   - On reaching TIMEOUT_CYCLES: go to HOLD with out_keep = lanes 0..cnt-1 set, unused lanes zero.
//  RD_PACK_TIMEOUT_EN undefined:
//   - No idle counter; out_keep is always all-ones; partial words wait indefinitely.
// STRUCTURE
//  Package fifo_rd_pkg:
//   - state typedef {FILL, HOLD}.
//   - localparams WORD_W = DATA_WIDTH*PACK_RATIO and CNT_W = $clog2(PACK_RATIO+1).
//  Sub-module pack_idle_timer (timeout counter; compiled only under RD_PACK_TIMEOUT_EN).
//   - ports: rd_clk, rst, clr, run, expired.
// TESTING
//  1. FIFO holds AA,BB,CC,DD; out_ready=1
//     -> one word 0xDDCCBBAA, out_keep=4'hF, exactly 4 fifo_rd pulses, none back-to-back.
//  2. 8 bytes 00..07, out_ready=0 until 20 cycles after first out_valid
//     -> 0x03020100 held stable, no fifo_rd during HOLD; then 0x07060504.
//  3. Only AA,BB written, macro on, TIMEOUT_CYCLES=16
//     -> 16 idle cycles after BB accepted: out_data[15:0]=0xBBAA, out_keep=4'h3.
//     Macro off: out_valid stays 0.
//  4. Assert rst after 2 bytes accepted, then write 11,22,33,44
//     -> first word is 0x44332211; earlier bytes never appear.
//  5. Force fifo_underflow=1 for one cycle
//     -> err_underflow=1 and stays 1 until rst.
//  6. Unsolicited fifo_valid pulse with data EE while idle -> ignored; next word unaffected.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_rd_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_PACK_RATIO     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  localparam int unsigned WORD_W = DEF_DATA_WIDTH * DEF_PACK_RATIO;
  localparam int unsigned CNT_W  = $clog2(DEF_PACK_RATIO + 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/pack_idle_timer.sv
// Idle counter that flushes a partial word after TIMEOUT_CYCLES quiet cycles.
// Only compiled when RD_PACK_TIMEOUT_EN is defined.
`ifdef RD_PACK_TIMEOUT_EN
module pack_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic rd_clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  // Count idle cycles; saturate on the last one so a blocked flush keeps firing.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run && (count_q != Last)) begin
      count_d = count_q + 1'b1;
    end
  end

  // The cycle that would complete TIMEOUT_CYCLES idle cycles.
  assign expired = run && !clr && (count_q == Last);

  // Counter register with synchronous reset.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: drains bytes one read at a time and packs PACK_RATIO
// of them into a word presented on a valid/ready handshake.
// Optional partial-word flush after an idle timeout: define RD_PACK_TIMEOUT_EN.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned PACK_RATIO     = DEF_PACK_RATIO,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         rd_clk,
  input  logic                         rst,
  output logic                         fifo_rd,
  input  logic [DATA_WIDTH-1:0]        fifo_rdata,
  input  logic                         fifo_valid,
  input  logic                         fifo_empty,
  input  logic                         fifo_underflow,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]        out_keep,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_underflow
);

  localparam int unsigned WordW = DATA_WIDTH * PACK_RATIO;
  localparam int unsigned CntW  = $clog2(PACK_RATIO + 1);
  localparam logic [CntW-1:0] LastLane = CntW'(PACK_RATIO - 1);

  if (PACK_RATIO < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic [WordW-1:0]      acc_q, acc_d;
  logic [WordW-1:0]      out_data_q, out_data_d;
  logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  flush;

  // One read in flight at most; never read while holding a word or in reset.
  always_comb begin
    fifo_rd = (state_q == FILL) && !fifo_empty && !inflight_q && !rst;
    accept  = fifo_valid && inflight_q;
  end

`ifdef RD_PACK_TIMEOUT_EN
  logic                  tmr_run, tmr_clr, tmr_expired;
  logic [PACK_RATIO-1:0] part_keep;

  // Timer runs only while a partial word waits with nothing outstanding.
  always_comb begin
    tmr_run = (state_q == FILL) && (cnt_q != '0) && !inflight_q;
    tmr_clr = accept || (state_q != FILL);
    // A read issued this cycle wins; its byte will clear the timer.
    flush   = tmr_expired && !fifo_rd;
    part_keep = '0;
    for (int i = 0; i < int'(PACK_RATIO); i++) begin
      part_keep[i] = (CntW'(i) < cnt_q);
    end
  end

  pack_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .rd_clk (rd_clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .run    (tmr_run),
    .expired(tmr_expired)
  );
`else
  assign flush = 1'b0;
`endif

  // Next-state: lane fill, word hand-off, sticky underflow.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    inflight_d  = fifo_rd;
    err_d       = err_q | fifo_underflow;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          acc_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastLane) begin
            out_data_d  = acc_d;
            out_keep_d  = '1;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (flush) begin
`ifdef RD_PACK_TIMEOUT_EN
          out_data_d  = acc_q;
          out_keep_d  = part_keep;
          out_valid_d = 1'b1;
          state_d     = HOLD;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          // Cleared so unused lanes of a later partial word read as zero.
          acc_d       = '0;
          state_d     = FILL;
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_keep      = out_keep_q;
  assign out_valid     = out_valid_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer with a queue-based FIFO and byte model.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned PR = DEF_PACK_RATIO;
  localparam int unsigned TO = 16;

  logic              rd_clk = 1'b0;
  logic              rst, fifo_rd, fifo_valid, fifo_empty, fifo_underflow;
  logic              out_valid, out_ready, err_underflow;
  logic [DW-1:0]     fifo_rdata;
  logic [WORD_W-1:0] out_data;
  logic [PR-1:0]     out_keep;

  fifo_rd_packer #(
    .DATA_WIDTH    (DW),
    .PACK_RATIO    (PR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .rd_clk        (rd_clk),
    .rst           (rst),
    .fifo_rd       (fifo_rd),
    .fifo_rdata    (fifo_rdata),
    .fifo_valid    (fifo_valid),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_underflow (err_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int                errors = 0;
  int                checks = 0;
  logic [DW-1:0]     fifo_q[$];
  logic [DW-1:0]     sent[$];
  logic [WORD_W-1:0] got_data[$];
  logic [PR-1:0]     got_keep[$];
  int                rd_pulses, accepted;
  logic              prev_rd, prev_hold;
  logic [WORD_W-1:0] prev_data;
  logic [PR-1:0]     prev_keep;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word k of the stream: PR consecutive bytes, first byte in the low lane.
  function automatic logic [WORD_W-1:0] model_word(input int k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int j = 0; j < int'(PR); j++) w[j*DW +: DW] = sent[k*PR + j];
    return w;
  endfunction

  // One clock: sample at negedge, then update the FIFO model after posedge.
  task automatic step();
    logic rd_now;
    @(negedge rd_clk);
    rd_now = fifo_rd;
    if (rd_now) rd_pulses++;
    if (fifo_valid) accepted++;
    check("rd_gap", 64'(rd_now & prev_rd), 64'(0));
    check("rd_in_hold", 64'(rd_now & out_valid), 64'(0));
    if (prev_hold) check("hold_stable", 64'({out_valid, out_keep, out_data}),
                         64'({1'b1, prev_keep, prev_data}));
    prev_hold = out_valid && !out_ready && !rst;
    prev_data = out_data;
    prev_keep = out_keep;
    if (out_valid && out_ready && !rst) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
    end
    prev_rd = rd_now;
    @(posedge rd_clk);
    #1;
    fifo_valid     = 1'b0;
    fifo_underflow = 1'b0;
    if (rd_now && fifo_q.size() > 0) begin
      fifo_rdata = fifo_q.pop_front();
      fifo_valid = 1'b1;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    sent.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete();
    sent.delete();
    fifo_empty = 1'b1;
    step();
    rst = 1'b0;
    got_data.delete();
    got_keep.delete();
    accepted  = 0;
    rd_pulses = 0;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got_data.size() < n; i++) step();
    check("word_count", 64'(got_data.size()), 64'(n));
  endtask

  task automatic check_words(input int n);
    for (int k = 0; k < n && k < got_data.size(); k++) begin
      check("model_data", 64'(got_data[k]), 64'(model_word(k)));
      check("model_keep", 64'(got_keep[k]), 64'({PR{1'b1}}));
    end
  endtask

  initial begin
    rst = 1'b1; fifo_valid = 1'b0; fifo_rdata = '0; fifo_empty = 1'b1;
    fifo_underflow = 1'b0; out_ready = 1'b0;
    prev_rd = 1'b0; prev_hold = 1'b0; prev_data = '0; prev_keep = '0;
    rd_pulses = 0; accepted = 0;
    repeat (2) @(posedge rd_clk);
    #1;
    do_reset();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_keep", 64'(out_keep), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));
    check("rst_rd", 64'(fifo_rd), 64'(0));

    // Single word, downstream always ready.
    out_ready = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    run_until(1, 60);
    if (got_data.size() > 0) check("t1_data", 64'(got_data[0]), 64'(32'hDDCCBBAA));
    check_words(1);
    repeat (5) step();
    check("t1_rd_pulses", 64'(rd_pulses), 64'(4));

    // Back-pressure: first word held stable for 20 cycles.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    for (int i = 0; i < 100 && !out_valid; i++) step();
    check("t2_valid", 64'(out_valid), 64'(1));
    check("t2_held", 64'(out_data), 64'(32'h03020100));
    repeat (20) step();
    check("t2_still", 64'(out_data), 64'(32'h03020100));
    out_ready = 1'b1;
    run_until(2, 100);
    if (got_data.size() > 1) check("t2_word1", 64'(got_data[1]), 64'(32'h07060504));
    check_words(2);

    // Partial word: flushed by timeout or held forever.
    do_reset();
    out_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    for (int i = 0; i < 50 && accepted < 2; i++) step();
    check("t3_accepted", 64'(accepted), 64'(2));
    repeat (10) step();
    check("t3_early", 64'(out_valid), 64'(0));
`ifdef RD_PACK_TIMEOUT_EN
    run_until(1, 30);
    if (got_data.size() > 0) begin
      check("t3_flush_data", 64'(got_data[0]), 64'(32'h0000BBAA));
      check("t3_flush_keep", 64'(got_keep[0]), 64'(4'h3));
    end
`else
    repeat (30) step();
    check("t3_no_flush", 64'(got_data.size()), 64'(0));
    check("t3_no_valid", 64'(out_valid), 64'(0));
`endif

    // Reset mid-word discards the partial bytes.
    do_reset();
    out_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    for (int i = 0; i < 50 && accepted < 2; i++) step();
    check("t4_accepted", 64'(accepted), 64'(2));
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_until(1, 60);
    if (got_data.size() > 0) begin
      check("t4_data", 64'(got_data[0]), 64'(32'h44332211));
      check("t4_keep", 64'(got_keep[0]), 64'(4'hF));
    end
    repeat (20) step();
    check("t4_count", 64'(got_data.size()), 64'(1));

    // Sticky underflow flag.
    check("t5_err_pre", 64'(err_underflow), 64'(0));
    fifo_underflow = 1'b1;
    step();
    check("t5_err_set", 64'(err_underflow), 64'(1));
    repeat (5) step();
    check("t5_err_sticky", 64'(err_underflow), 64'(1));
    do_reset();
    check("t5_err_clr", 64'(err_underflow), 64'(0));

    // Unsolicited fifo_valid is dropped.
    out_ready  = 1'b1;
    fifo_rdata = 8'hEE;
    fifo_valid = 1'b1;
    step();
    repeat (3) step();
    check("t6_idle", 64'(out_valid), 64'(0));
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    run_until(1, 60);
    if (got_data.size() > 0) check("t6_data", 64'(got_data[0]), 64'(32'h8D7C6B5A));

    // Random bytes with random back-pressure against the byte-stream model.
    do_reset();
    for (int k = 0; k < 40; k++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3000 && got_data.size() < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("t7_count", 64'(got_data.size()), 64'(10));
    check_words(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
